osu_sc_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters, e.g. a shared output net driven through an OR-reduced request path. It issues a registered one-hot grant, holds the grant while the winner keeps requesting, and forces rotation after a programmable hold limit. It also exports the combinational OR of all requests as a resource-demand flag. It is built for synthesis onto the 3.3 V 9-track OSU cell set: OR/AND/INV cells plus reset flops.

---
 rtl/osu_sc_arb_pkg.sv | 20 ++
 rtl/osu_sc_rr_pick.sv | 30 +++
 rtl/osu_sc_rr_arbiter.sv | 115 +++++++++++
 tb/tb_osu_sc_rr_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/osu_sc_arb_pkg.sv
// Shared types and helpers for the OSU round-robin arbiter.
// Holds the counter width, the FSM state encoding and a one-hot decoder.
package osu_sc_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Bits at or above n stay clear, so callers can size-cast the result to n bits.
  function automatic logic [15:0] onehot(input logic [3:0] idx, input int n);
    logic [15:0] r;
    r = '0;
    if (int'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/osu_sc_rr_pick.sv
// Circular first-set search over a request vector, starting at a given index.
// Purely combinational: found/win follow the inputs with no clock and no backpressure.
module osu_sc_rr_pick #(
  parameter  int N  = 4,
  localparam int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] start,
  input  logic          excl_en,
  input  logic [GW-1:0] excl_idx,
  output logic          found,
  output logic [GW-1:0] win
);

  int idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(start) + i) % N;
      if (!found && req[idx] && !(excl_en && (idx == int'(excl_idx)))) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/osu_sc_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant one edge after request, hold limit forces rotation.
// No backpressure: the grant is held while the winner keeps REQ high; ANY is the raw OR of REQ.
module osu_sc_rr_arbiter
  import osu_sc_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int HOLD_MAX = 8,
  localparam int GW       = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [GW-1:0] GID,
  output logic          VALID,
  output logic          ANY
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = (HOLD_MAX == 0) ? 8'd255 : CNT_W'(HOLD_MAX);

  arb_state_t       state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic             valid_q, valid_d;

  logic [GW-1:0]    nxt;
  logic [GW-1:0]    pick_start;
  logic             pick_found;
  logic [GW-1:0]    pick_win;

  assign nxt        = (gid_q == GW'(N - 1)) ? '0 : gid_q + 1'b1;
  assign pick_start = (state_q == IDLE) ? ptr_q : nxt;

  // While granted, the current holder is never a candidate: on release it is not requesting anyway.
  osu_sc_rr_pick #(.N(N)) u_pick (
    .req      (REQ),
    .start    (pick_start),
    .excl_en  (state_q == GRANT),
    .excl_idx (gid_q),
    .found    (pick_found),
    .win      (pick_win)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = N'(onehot(4'(pick_win), N));
          gid_d   = pick_win;
          valid_d = 1'b1;
          cnt_d   = 8'd1;
          state_d = GRANT;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!REQ[gid_q]) begin
          ptr_d = nxt;
          if (pick_found) begin
            gnt_d = N'(onehot(4'(pick_win), N));
            gid_d = pick_win;
            cnt_d = 8'd1;
          end else begin
            gnt_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if ((HOLD_MAX != 0) && (cnt_q == HOLD_LIM) && pick_found) begin
          gnt_d = N'(onehot(4'(pick_win), N));
          gid_d = pick_win;
          ptr_d = nxt;
          cnt_d = 8'd1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      valid_q <= valid_d;
    end
  end

  assign GNT   = gnt_q;
  assign GID   = gid_q;
  assign VALID = valid_q;
  assign ANY   = |REQ;

endmodule

// File: tb/tb_osu_sc_rr_arbiter.sv
// Directed bench for osu_sc_rr_arbiter: a vector table plus hand-written multi-cycle sequences.
// Three instances cover hold limits of 2, 3 and unlimited.
module tb_osu_sc_rr_arbiter;

  logic       CLK;
  logic       RN;
  logic [3:0] req_a, gnt_a, req_b, gnt_b, req_c, gnt_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic       vld_a, vld_b, vld_c;
  logic       any_a, any_b, any_c;

  int checks = 0;
  int errors = 0;

  osu_sc_rr_arbiter #(.N(4), .HOLD_MAX(2)) dut_a (
    .CLK(CLK), .RN(RN), .REQ(req_a), .GNT(gnt_a), .GID(gid_a), .VALID(vld_a), .ANY(any_a)
  );
  osu_sc_rr_arbiter #(.N(4), .HOLD_MAX(3)) dut_b (
    .CLK(CLK), .RN(RN), .REQ(req_b), .GNT(gnt_b), .GID(gid_b), .VALID(vld_b), .ANY(any_b)
  );
  osu_sc_rr_arbiter #(.N(4), .HOLD_MAX(0)) dut_c (
    .CLK(CLK), .RN(RN), .REQ(req_c), .GNT(gnt_c), .GID(gid_c), .VALID(vld_c), .ANY(any_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       vld;
    logic       any;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RN = 1'b0;
    #3;
    RN = 1'b1;
  endtask

  int tally [4];
  logic [1:0] exp_gid;
  logic [3:0] exp_oh;

  initial begin
    // HOLD_MAX=2, starting from reset (PTR=0, idle)
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1}; // limit hit but nobody else asks
    tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}; // release, PTR->3, GID kept
    tbl[5]  = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1}; // search from PTR=3
    tbl[6]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1}; // handoff with wrap 3->0
    tbl[7]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[8]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1}; // forced rotation
    tbl[9]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[10] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1}; // rotation wraps past 2,3
    tbl[11] = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1}; // release, search from 1
    tbl[12] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

    RN = 1'b0;
    req_a = 4'b1111; req_b = 4'b1111; req_c = 4'b1111;
    #12;
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_vld", 32'(vld_a), 32'h0);
    chk("rst_gid", 32'(gid_a), 32'h0);
    chk("rst_any", 32'(any_a), 32'h1);
    chk("rst_gnt_b", 32'(gnt_b), 32'h0);
    tick();
    chk("rst_held_gnt", 32'(gnt_a), 32'h0);
    req_a = 4'b0000; req_b = 4'b0000; req_c = 4'b0000;
    RN = 1'b1;

    for (int i = 0; i < 14; i++) begin
      req_a = tbl[i].req;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt_a), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_gid", i), 32'(gid_a), 32'(tbl[i].gid));
      chk($sformatf("vec%0d_vld", i), 32'(vld_a), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_any", i), 32'(any_a), 32'(tbl[i].any));
    end

    // Round robin fairness with HOLD_MAX=2
    do_reset();
    for (int r = 0; r < 4; r++) tally[r] = 0;
    req_a = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      tick();
      exp_gid = 2'((c / 2) % 4);
      exp_oh  = 4'b0001 << exp_gid;
      chk($sformatf("rr%0d_gnt", c), 32'(gnt_a), 32'(exp_oh));
      chk($sformatf("rr%0d_vld", c), 32'(vld_a), 32'h1);
      if (vld_a) tally[gid_a]++;
    end
    for (int r = 0; r < 4; r++) chk($sformatf("rr_tally%0d", r), 32'(tally[r]), 32'd4);
    req_a = 4'b0000;
    tick();
    chk("rr_idle_vld", 32'(vld_a), 32'h0);

    // Hold limit 3: lone requester keeps the grant, then rotation on the saturated count
    req_b = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("hold%0d_gnt", c), 32'(gnt_b), 32'h2);
    end
    req_b = 4'b0011;
    tick();
    chk("hold_rot0_gnt", 32'(gnt_b), 32'h1);
    chk("hold_rot0_gid", 32'(gid_b), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("hold_keep%0d_gnt", c), 32'(gnt_b), 32'h1);
    end
    tick();
    chk("hold_rot1_gnt", 32'(gnt_b), 32'h2);
    req_b = 4'b0000;

    // Unlimited hold: requester 0 never loses the grant
    req_c = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("nolim%0d_gnt", c), 32'(gnt_c), 32'h1);
    end
    req_c = 4'b0000;

    // Async reset in the middle of a grant to requester 3
    do_reset();
    req_a = 4'b1000;
    tick();
    chk("ar_pre_gnt", 32'(gnt_a), 32'h8);
    #2;
    RN = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt_a), 32'h0);
    chk("ar_vld", 32'(vld_a), 32'h0);
    chk("ar_gid", 32'(gid_a), 32'h0);
    req_a = 4'b1010;
    @(negedge CLK);
    RN = 1'b1;
    tick();
    chk("ar_post_gnt", 32'(gnt_a), 32'h2);
    chk("ar_post_gid", 32'(gid_a), 32'h1);
    chk("ar_post_vld", 32'(vld_a), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
